// File: rtl/switch_debounce_if.sv
// Push-button debouncer signal bundle.
// master : drives the raw switch level and observes the debounced outputs (bench side)
// slave  : the debouncer itself
// Signals: i_Switch (raw level), o_Switch (debounced level), o_Press / o_Release
// (one-clock edge strobes), o_Long_Press (one-clock hold strobe, LONG_PRESS_EN only).
interface switch_debounce_if;
    logic i_Switch;
    logic o_Switch;
    logic o_Press;
    logic o_Release;
`ifdef LONG_PRESS_EN
    logic o_Long_Press;

    modport master (output i_Switch, input o_Switch, o_Press, o_Release, o_Long_Press);
    modport slave  (input i_Switch, output o_Switch, o_Press, o_Release, o_Long_Press);
`else
    modport master (output i_Switch, input o_Switch, o_Press, o_Release);
    modport slave  (input i_Switch, output o_Switch, o_Press, o_Release);
`endif
endinterface

// File: rtl/switch_debounce.sv
// Push-button debouncer: two-flop synchronizer, persistence counter, registered
// debounced level plus press/release strobes.
// Optional macro LONG_PRESS_EN adds a hold counter and a one-shot o_Long_Press strobe.
// Ports: i_Clk (rising-edge clock), i_Rst_L (async active-low reset),
//        sw (switch_debounce_if.slave: i_Switch in; o_Switch, o_Press, o_Release,
//        o_Long_Press out).
module switch_debounce #(
    parameter int unsigned DEBOUNCE_LIMIT   = 250000,
    parameter int unsigned LONG_PRESS_LIMIT = 25000000
) (
    input  logic              i_Clk,
    input  logic              i_Rst_L,
    switch_debounce_if.slave  sw
);
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_LIMIT - 1);

    // Elaboration-time parameter range guard
    if (DEBOUNCE_LIMIT < 2 || DEBOUNCE_LIMIT > (1 << 20)) begin : g_bad_debounce
        $error("DEBOUNCE_LIMIT out of range 2..2^20");
    end
    if (LONG_PRESS_LIMIT < 2 || LONG_PRESS_LIMIT > (1 << 26)) begin : g_bad_long
        $error("LONG_PRESS_LIMIT out of range 2..2^26");
    end

    logic             sync1_q, sync1_d;
    logic             sync_q, sync_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             switch_q, switch_d;
    logic             press_q, press_d;
    logic             release_q, release_d;

    // Synchronizer and debounce state
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            sync1_q   <= 1'b0;
            sync_q    <= 1'b0;
            cnt_q     <= '0;
            switch_q  <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync_q    <= sync_d;
            cnt_q     <= cnt_d;
            switch_q  <= switch_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    // Count consecutive disagreeing clocks; accept the new level on the last one
    always_comb begin
        sync1_d   = sw.i_Switch;
        sync_d    = sync1_q;
        cnt_d     = '0;
        switch_d  = switch_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (sync_q != switch_q) begin
            if (cnt_q == CNT_MAX) begin
                switch_d  = sync_q;
                press_d   = sync_q;
                release_d = ~sync_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign sw.o_Switch  = switch_q;
    assign sw.o_Press   = press_q;
    assign sw.o_Release = release_q;

`ifdef LONG_PRESS_EN
    localparam int unsigned HOLD_W = $clog2(LONG_PRESS_LIMIT);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_PRESS_LIMIT - 1);

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              done_q, done_d;
    logic              long_q, long_d;

    // Long-press hold state
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            hold_q <= '0;
            done_q <= 1'b0;
            long_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            done_q <= done_d;
            long_q <= long_d;
        end
    end

    // Hold counter freezes once the strobe fires so each press yields one pulse
    always_comb begin
        hold_d = hold_q;
        done_d = done_q;
        long_d = 1'b0;
        if (!switch_q) begin
            hold_d = '0;
            done_d = 1'b0;
        end else if (!done_q) begin
            if (hold_q == HOLD_MAX) begin
                long_d = 1'b1;
                done_d = 1'b1;
            end else begin
                hold_d = hold_q + HOLD_W'(1);
            end
        end
    end

    assign sw.o_Long_Press = long_q;
`endif
endmodule

// File: tb/tb_switch_debounce.sv
// Self-checking bench for switch_debounce (DEBOUNCE_LIMIT=4, LONG_PRESS_LIMIT=10).
// Expected output events (edge index + kind) are queued when stimulus is driven and
// compared against events recorded from the DUT outputs.
module tb_switch_debounce;
    localparam int unsigned DL = 4;
    localparam int unsigned LL = 10;

    localparam int K_UP   = 0;
    localparam int K_DN   = 1;
    localparam int K_PRS  = 2;
    localparam int K_REL  = 3;
    localparam int K_LONG = 4;

    typedef struct {
        int cyc;
        int kind;
    } ev_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic prev_sw = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    ev_t  exp_q[$];
    ev_t  obs_q[$];

    switch_debounce_if sw_if ();

    switch_debounce #(
        .DEBOUNCE_LIMIT  (DL),
        .LONG_PRESS_LIMIT(LL)
    ) dut (
        .i_Clk  (clk),
        .i_Rst_L(rst_n),
        .sw     (sw_if.slave)
    );

    always #5 clk = ~clk;

    // Advance one edge, sample 1 ns later and record any output events
    task automatic step();
        ev_t e;
        @(posedge clk);
        #1;
        cyc++;
        e.cyc = cyc;
        if (sw_if.o_Switch !== prev_sw) begin
            e.kind = (sw_if.o_Switch === 1'b1) ? K_UP : K_DN;
            obs_q.push_back(e);
        end
        prev_sw = sw_if.o_Switch;
        if (sw_if.o_Press !== 1'b0)   begin e.kind = K_PRS; obs_q.push_back(e); end
        if (sw_if.o_Release !== 1'b0) begin e.kind = K_REL; obs_q.push_back(e); end
`ifdef LONG_PRESS_EN
        if (sw_if.o_Long_Press !== 1'b0) begin e.kind = K_LONG; obs_q.push_back(e); end
`endif
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic expect_ev(input int c, input int k);
        ev_t e;
        e.cyc  = c;
        e.kind = k;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        int r;
        sw_if.i_Switch = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({sw_if.o_Switch, sw_if.o_Press, sw_if.o_Release} !== 3'b000) begin
            failures++;
            $display("FAIL reset_async outputs=%b exp=000",
                     {sw_if.o_Switch, sw_if.o_Press, sw_if.o_Release});
        end
        run(3);
        checks++;
        if ({sw_if.o_Switch, sw_if.o_Press, sw_if.o_Release, dut.cnt_q} !== 5'b0) begin
            failures++;
            $display("FAIL reset_held outputs=%b cnt=%0d exp=000 cnt=0",
                     {sw_if.o_Switch, sw_if.o_Press, sw_if.o_Release}, dut.cnt_q);
        end
        obs_q.delete();
        rst_n = 1'b1;
        r = cyc;
        expect_ev(r + 6, K_UP);
        expect_ev(r + 6, K_PRS);
        run(12);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            failures++;
            $display("FAIL reset_events count got=%0d exp=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            ev_t e, o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o.cyc !== e.cyc || o.kind !== e.kind) begin
                failures++;
                $display("FAIL reset_event got=(cyc %0d kind %0d) exp=(cyc %0d kind %0d)",
                         o.cyc, o.kind, e.cyc, e.kind);
            end
        end
        exp_q.delete(); obs_q.delete();
        checks++;
        if (sw_if.o_Switch !== 1'b1) begin
            failures++;
            $display("FAIL reset_level got=%b exp=1", sw_if.o_Switch);
        end
    endtask

    task automatic test_glitch();
        int n;
        // Pressed: a 3-clock low gap must be ignored
        for (int i = 0; i < 3; i++) begin sw_if.i_Switch = 1'b0; step(); end
        sw_if.i_Switch = 1'b1;
        run(10);
        checks++;
        if (sw_if.o_Switch !== 1'b1) begin
            failures++;
            $display("FAIL glitch_low_level got=%b exp=1", sw_if.o_Switch);
        end
        // Held low long enough: exactly one release
        sw_if.i_Switch = 1'b0;
        n = cyc + 1;
        expect_ev(n + 5, K_DN);
        expect_ev(n + 5, K_REL);
        run(10);
        // Released: a 3-clock high pulse must be ignored
        for (int i = 0; i < 3; i++) begin sw_if.i_Switch = 1'b1; step(); end
        sw_if.i_Switch = 1'b0;
        run(10);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            failures++;
            $display("FAIL glitch_events count got=%0d exp=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            ev_t e, o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o.cyc !== e.cyc || o.kind !== e.kind) begin
                failures++;
                $display("FAIL glitch_event got=(cyc %0d kind %0d) exp=(cyc %0d kind %0d)",
                         o.cyc, o.kind, e.cyc, e.kind);
            end
        end
        exp_q.delete(); obs_q.delete();
        checks++;
        if (sw_if.o_Switch !== 1'b0) begin
            failures++;
            $display("FAIL glitch_high_level got=%b exp=0", sw_if.o_Switch);
        end
    endtask

    task automatic test_clean_press();
        int n;
        sw_if.i_Switch = 1'b1;
        n = cyc + 1;
        expect_ev(n + 5, K_UP);
        expect_ev(n + 5, K_PRS);
        step();
        sw_if.i_Switch = 1'b1;
        run(5);
        // Drop right after acceptance: release five edges after the first low sample
        sw_if.i_Switch = 1'b0;
        n = cyc + 1;
        expect_ev(n + 5, K_DN);
        expect_ev(n + 5, K_REL);
        run(10);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            failures++;
            $display("FAIL clean_events count got=%0d exp=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            ev_t e, o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o.cyc !== e.cyc || o.kind !== e.kind) begin
                failures++;
                $display("FAIL clean_event got=(cyc %0d kind %0d) exp=(cyc %0d kind %0d)",
                         o.cyc, o.kind, e.cyc, e.kind);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_bounce();
        int n;
        logic [4:0] pat;
        pat = 5'b01101;  // applied LSB first: 1,0,1,1,0
        n = cyc + 1;
        for (int i = 0; i < 5; i++) begin sw_if.i_Switch = pat[i]; step(); end
        sw_if.i_Switch = 1'b1;
        // Steady 1 from sample n+5, so sync settles at n+6 and acceptance is at n+10
        expect_ev(n + 10, K_UP);
        expect_ev(n + 10, K_PRS);
        run(12);
        sw_if.i_Switch = 1'b0;
        n = cyc + 1;
        expect_ev(n + 5, K_DN);
        expect_ev(n + 5, K_REL);
        run(10);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            failures++;
            $display("FAIL bounce_events count got=%0d exp=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            ev_t e, o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o.cyc !== e.cyc || o.kind !== e.kind) begin
                failures++;
                $display("FAIL bounce_event got=(cyc %0d kind %0d) exp=(cyc %0d kind %0d)",
                         o.cyc, o.kind, e.cyc, e.kind);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_long_press();
        int n;
        sw_if.i_Switch = 1'b1;
        n = cyc + 1;
        expect_ev(n + 5, K_UP);
        expect_ev(n + 5, K_PRS);
`ifdef LONG_PRESS_EN
        expect_ev(n + 5 + int'(LL), K_LONG);
`endif
        run(30);
        sw_if.i_Switch = 1'b0;
        expect_ev(n + 35, K_DN);
        expect_ev(n + 35, K_REL);
        run(12);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            failures++;
            $display("FAIL long_events count got=%0d exp=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            ev_t e, o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o.cyc !== e.cyc || o.kind !== e.kind) begin
                failures++;
                $display("FAIL long_event got=(cyc %0d kind %0d) exp=(cyc %0d kind %0d)",
                         o.cyc, o.kind, e.cyc, e.kind);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_mid_reset();
        int r;
        sw_if.i_Switch = 1'b1;
        run(4);
        checks++;
        if (dut.cnt_q !== 2'd2) begin
            failures++;
            $display("FAIL midrst_precount got=%0d exp=2", dut.cnt_q);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({dut.cnt_q, dut.sync1_q, dut.sync_q, sw_if.o_Switch, sw_if.o_Press,
             sw_if.o_Release} !== 7'b0) begin
            failures++;
            $display("FAIL midrst_clear cnt=%0d sync=%b%b outs=%b exp=all 0",
                     dut.cnt_q, dut.sync1_q, dut.sync_q,
                     {sw_if.o_Switch, sw_if.o_Press, sw_if.o_Release});
        end
        rst_n = 1'b1;
        r = cyc;
        expect_ev(r + 6, K_UP);
        expect_ev(r + 6, K_PRS);
        run(12);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            failures++;
            $display("FAIL midrst_events count got=%0d exp=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            ev_t e, o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o.cyc !== e.cyc || o.kind !== e.kind) begin
                failures++;
                $display("FAIL midrst_event got=(cyc %0d kind %0d) exp=(cyc %0d kind %0d)",
                         o.cyc, o.kind, e.cyc, e.kind);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    initial begin
        sw_if.i_Switch = 1'b0;
        test_reset();
        test_glitch();
        test_clean_press();
        test_bounce();
        test_long_press();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/switch_debounce.md
SWITCH_DEBOUNCE -- requirements
Module: switch_debounce

Interface
REQ-001 The block SHALL have a parameter DEBOUNCE_LIMIT, default 250000, meaning the number of consecutive clocks a synchronized input change must persist to be accepted (10 ms at 25 MHz); legal range 2..2^20.
REQ-002 The block SHALL have a parameter LONG_PRESS_LIMIT, default 25000000, meaning the number of clocks the debounced level must stay high before a long-press pulse (1 s at 25 MHz); legal range 2..2^26; used only when LONG_PRESS_EN is defined.
REQ-003 i_Clk  input  1  single system clock; all flops are rising-edge.
REQ-004 i_Rst_L  input  1  asynchronous, active-low reset.
REQ-005 i_Switch  input  1  raw, asynchronous, bouncing push-button level (1 = pressed).
REQ-006 o_Switch  output  1  registered, debounced switch level.
REQ-007 o_Press  output  1  registered one-clock pulse on an accepted 0->1 transition of o_Switch.
REQ-008 o_Release  output  1  registered one-clock pulse on an accepted 1->0 transition of o_Switch; this is the toggle strobe for downstream LED logic.
REQ-009 o_Long_Press  output  1  registered one-clock pulse on long-press detection; present only when LONG_PRESS_EN is defined.

Function
REQ-010 i_Switch SHALL pass through a two-flop synchronizer; only the second flop output (sync) SHALL feed the debounce logic.
REQ-011 A debounce counter of width clog2(DEBOUNCE_LIMIT) SHALL clear to 0 on any clock where sync equals o_Switch.
REQ-012 On a clock where sync differs from o_Switch and the counter is below DEBOUNCE_LIMIT-1, the counter SHALL increment by 1.
REQ-013 On a clock where sync differs from o_Switch and the counter equals DEBOUNCE_LIMIT-1, o_Switch SHALL take the value of sync and the counter SHALL clear to 0.
REQ-014 Net latency: a clean level change sampled at i_Switch on rising edge N SHALL appear on o_Switch after edge N+DEBOUNCE_LIMIT+1.
REQ-015 Any sync pulse or gap shorter than DEBOUNCE_LIMIT clocks SHALL leave o_Switch, o_Press and o_Release unchanged.
REQ-016 o_Press SHALL be 1 for exactly the clock following the edge at which o_Switch changes 0->1, else 0; o_Release likewise for 1->0; the two SHALL never be high together.
REQ-017 Counter SHALL never wrap; it saturates by clearing per REQ-013.

Reset
REQ-018 While i_Rst_L = 0, both synchronizer flops, the debounce counter, o_Switch, o_Press, o_Release and (if present) the long-press counter, long-press done flag and o_Long_Press SHALL be 0 immediately, independent of i_Clk.
REQ-019 Reset deassertion mid-bounce SHALL start debouncing from o_Switch = 0 and counter = 0; a switch held high through reset SHALL produce o_Press after DEBOUNCE_LIMIT+2 edges following release of reset, with no o_Release.

Configuration
REQ-020 Macro LONG_PRESS_EN SHALL compile in the long-press feature; without it o_Long_Press, its counter and flag SHALL be absent and all other behaviour identical.
REQ-021 With LONG_PRESS_EN: a hold counter of width clog2(LONG_PRESS_LIMIT) SHALL increment each clock o_Switch = 1 and the done flag is 0, and clear when o_Switch = 0.
REQ-022 With LONG_PRESS_EN: when the hold counter reaches LONG_PRESS_LIMIT-1, o_Long_Press SHALL pulse high for one clock and the done flag SHALL set, so at most one pulse per press; flag clears when o_Switch returns to 0.
REQ-023 With LONG_PRESS_EN: a release after the long-press pulse SHALL still generate o_Release.

Verification (DEBOUNCE_LIMIT = 4, LONG_PRESS_LIMIT = 10)
REQ-024 Reset asserted, i_Switch = 1 -> all outputs 0 during reset; after release, o_Switch = 1 and o_Press pulse on edge 6, no o_Release.
REQ-025 i_Switch 0->1 clean, sampled edge N -> o_Switch high after edge N+5, o_Press high for exactly that one clock.
REQ-026 i_Switch bounces 1,0,1,1,0 per clock then steady 1 -> single o_Press, 4 edges after sync settles steady; no intermediate transitions.
REQ-027 Pressed, then i_Switch low for 3 clocks, then high -> no o_Release, o_Switch stays 1; then low for 4+ clocks -> one o_Release pulse.
REQ-028 LONG_PRESS_EN defined, press held 30 clocks -> exactly one o_Long_Press pulse 10 clocks after o_Switch rises, then one o_Release on release; undefined -> port absent, same o_Press/o_Release timing.
REQ-029 i_Rst_L pulsed low asynchronously mid-count (counter = 2) -> outputs and counter 0 at once; debouncing restarts from 0 after release.
